// File: rtl/fetch_queue.sv
// fetch_queue: decoupled RV32I instruction-fetch stage.
//
// A PC generator issues one-cycle synchronous instruction-memory requests.
// Returned words are pushed into a DEPTH-entry circular queue of {pc, instr}.
// The queue feeds ID through a valid/ready handshake. An EX redirect flushes
// the queue and restarts fetch at the target in the same cycle.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active low
//   imem_req     fetch request this cycle
//   imem_addr    word-aligned fetch address
//   imem_rdata   instruction for the request issued in the previous cycle
//   redirect     EX branch taken / jump: flush and refetch
//   redirect_pc  redirect target (bits [1:0] ignored)
//   out_valid    head entry presented to ID
//   out_ready    ID accepts the head entry
//   out_pc       PC of head entry, 0 when empty
//   out_instr    head instruction, NOP when empty
//   count        current queue occupancy
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  // one extra bit so count + pending cannot overflow before the compare
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic            pending;
  logic [XLEN-1:0] pend_pc;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;
  entry_t          mem [DEPTH];

  logic            head_vld;
  logic            pop;
  logic            wr_en;
  logic [XLEN-1:0] tgt;
  logic [OW-1:0]   occ;
  logic            unused_bits;

  assign unused_bits = ^redirect_pc[1:0];
  assign tgt         = {redirect_pc[XLEN-1:2], 2'b00};

  // Head is only meaningful out of reset; this also forces the empty-queue
  // values on the head outputs while rst is held low.
  assign head_vld  = rst && (cnt != '0);
  assign out_valid = head_vld && !redirect;
  assign pop       = out_valid && out_ready;

  // Data for last cycle's request; dropped on redirect (it is on the wrong
  // path) and gated by rst so a pre-reset request never lands.
  assign wr_en = rst && pending && !redirect;

  // Entries already held plus the one in flight, minus the one leaving now.
  // Issue only if the result still leaves room, so a write can never hit a
  // full queue. pop implies cnt >= 1, so this never underflows.
  assign occ = OW'(cnt) + OW'(pending) - OW'(pop);

  assign imem_req  = rst && (redirect || (occ < OW'(DEPTH)));
  assign imem_addr = redirect ? tgt : fetch_pc;

  assign out_pc    = head_vld ? mem[rd_ptr].pc    : '0;
  assign out_instr = head_vld ? mem[rd_ptr].instr : NOP;
  assign count     = rst ? cnt : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      pending  <= 1'b0;
      pend_pc  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else if (redirect) begin
      // Flush by catching the read pointer up to the write pointer; the
      // target request goes out this cycle, so it is already in flight.
      cnt      <= '0;
      rd_ptr   <= wr_ptr;
      pending  <= 1'b1;
      pend_pc  <= tgt;
      fetch_pc <= tgt + XLEN'(4);
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(wr_en) - CW'(pop);
      if (imem_req) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        pending  <= 1'b1;
        pend_pc  <= fetch_pc;
      end else begin
        pending  <= 1'b0;
      end
    end
  end

  // Storage needs no reset: entries are only read when cnt says they exist.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{pc: pend_pc, instr: imem_rdata};
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised decoupled instruction-fetch stage for the RV32I core. It replaces the single-register IF stage with a PC generator, a one-cycle synchronous instruction-memory request port and a DEPTH-entry instruction queue feeding ID through a valid/ready handshake. Branch and jump redirects from EX flush the queue and restart fetch at the target in the same cycle. An ID stall (load-use bubble) no longer blocks fetch until the queue is full.

## Interface
- XLEN, 32: PC and address width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: first fetch address after reset.
- NOP, 32'h00000013: value driven on out_instr when the queue is empty.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low (asserted at 0).
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  XLEN  fetch address, word aligned.
- imem_rdata  in  32  instruction for the request issued in the previous cycle.
- redirect  in  1  EX branch taken / jump; flush and refetch.
- redirect_pc  in  XLEN  target; bits [1:0] ignored (treated as 0).
- out_valid  out  1  head entry presented to ID.
- out_ready  in  1  ID accepts the head entry (~bubble).
- out_pc  out  XLEN  PC of head entry; 0 when empty.
- out_instr  out  32  head instruction; NOP when empty.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- State:
  - fetch_pc: next sequential address.
  - pending: a request was issued last cycle.
  - pend_pc: address of that request.
  - Circular buffer of {pc, instr} with rd_ptr and wr_ptr, each $clog2(DEPTH) bits, which wrap naturally.
  - count.
- pop = out_valid && out_ready.
- out_valid = (count != 0) && !redirect.
- Write: when pending && !redirect, store {pend_pc, imem_rdata} at wr_ptr and increment wr_ptr.
- Issue rule, no redirect:
  - imem_req = (count + pending − pop) < DEPTH.
  - imem_addr = fetch_pc.
  - On issue: fetch_pc += 4, pending <= 1, pend_pc <= fetch_pc.
  - Otherwise: pending <= 0.
- Redirect cycle:
  - Clear the queue: count <= 0, rd_ptr <= wr_ptr.
  - Drop any imem_rdata arriving this cycle.
  - Ignore out_ready.
  - Drive imem_req=1, imem_addr={redirect_pc[XLEN-1:2],2'b00}.
  - Update: pending <= 1, pend_pc <= that address, fetch_pc <= that address + 4.
  - Redirect takes priority over the issue rule.
- count update: +1 on write, −1 on pop; both in the same cycle leaves count unchanged.
- A write while full is impossible by the issue rule; the bench asserts it never occurs.
- PC arithmetic is modulo 2^XLEN; wrap from 0xFFFFFFFC to 0 is legal and silent.

## Timing
- Reset: while rst=0 at a clock edge:
  - fetch_pc <= RESET_PC; pending, count, rd_ptr, wr_ptr <= 0.
  - imem_req, out_valid are 0 while rst=0 (combinational gating); out_instr=NOP, out_pc=0, count=0.
- First request: in the first cycle after rst rises, with imem_addr=RESET_PC.
- Request latency: request at cycle t → data written at the end of t+1 → out_valid=1 at t+2.
- Redirect latency: redirect at t → target fetched at t → entry visible at t+2.
- Throughput: with DEPTH≥2 and out_ready held at 1, one instruction per cycle, with no bubbles after the initial 2-cycle fill.
- Backpressure:
  - out_ready=0 fills the queue to DEPTH.
  - imem_req drops in the cycle where count + pending = DEPTH.
  - Issue resumes combinationally in the first cycle out_ready=1.
- Reset mid-operation: all state cleared at that edge; rdata from a pre-reset request is never written.
- Head outputs (out_pc, out_instr) change only on pop, write-to-empty, redirect, or reset.

## Test plan
- Streaming after reset:
  - Stimulus: RESET_PC=0, imem returns addr>>2, out_ready=1.
  - Required: imem_addr 0,4,8,…; out_valid rises 2 cycles after reset release; out_pc 0,4,8 on consecutive cycles with instr 0,1,2.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles.
  - Required: count reaches 4; imem_req low with last request addr 0xC; on release, out_pc 0x0,0x4,0x8,0xC,0x10 are consumed back-to-back with none lost or duplicated.
- Redirect mid-stream:
  - Stimulus: redirect with redirect_pc=0x103 while count=3.
  - Required: same cycle imem_addr=0x100; rdata arriving that cycle dropped; out_valid=0 for that cycle and the next; next out_pc=0x100, then 0x104.
- Redirect with simultaneous pop and full queue:
  - Required: no pop counted; count=0 after the edge; no assertion fires.
- Pointer wrap:
  - Stimulus: 3·DEPTH+1 instructions under random out_ready.
  - Required: in-order, gap-free PC sequence; count always within 0..DEPTH.
- Reset mid-operation:
  - Stimulus: rst=0 for 1 cycle with count=2 and pending=1.
  - Required: next cycle count=0, out_instr=0x00000013; first request after release at RESET_PC.
